// File: rtl/vec_activate_if.sv
// ---------------------------------------------------------------------------
// vec_activate_if
//
// Purpose : bundles the handshake, upstream/bias read-select and result
//           read-port signals of vec_activate into one interface.
//
// Signals :
//   start     sweep request (sampled only while the block is idle)
//   act_sel   activation select: 00 identity, 01 hard sigmoid,
//             10 hard tanh, 11 ReLU
//   data_in   signed upstream element addressed by sel_in (combinational)
//   bias_in   signed bias element addressed by sel_bias (combinational)
//   sel       read index into the result vector
//   ready     high while idle and the result vector is valid
//   data_out  result[sel], combinational read
//   sel_in    index driven to the upstream vector read select
//   sel_bias  index driven to the bias vector read select
//
// Modports:
//   master  the side that requests sweeps, supplies vectors and reads results
//   slave   vec_activate itself
// ---------------------------------------------------------------------------
interface vec_activate_if #(
  parameter int LEN_BITS = 4
);

  logic                start;
  logic [1:0]          act_sel;
  logic signed [15:0]  data_in;
  logic signed [15:0]  bias_in;
  logic [LEN_BITS-1:0] sel;
  logic                ready;
  logic signed [15:0]  data_out;
  logic [LEN_BITS-1:0] sel_in;
  logic [LEN_BITS-1:0] sel_bias;

  modport master (
    output start,
    output act_sel,
    output data_in,
    output bias_in,
    output sel,
    input  ready,
    input  data_out,
    input  sel_in,
    input  sel_bias
  );

  modport slave (
    input  start,
    input  act_sel,
    input  data_in,
    input  bias_in,
    input  sel,
    output ready,
    output data_out,
    output sel_in,
    output sel_bias
  );

endinterface

// File: rtl/vec_activate.sv
// ---------------------------------------------------------------------------
// vec_activate
//
// Purpose : post-multiply stage. On start it sweeps the upstream result
//           vector one element per cycle (through sel_in/data_in), optionally
//           adds a per-element bias, applies a fixed-point activation and
//           stores the result in an internal N-entry vector that is read back
//           combinationally through sel/data_out.
//
// Parameters:
//   LEN_BITS   log2 of vector length (N = 2**LEN_BITS)
//   FRAC_BITS  fractional bits of the signed 16-bit fixed-point format
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    vec_activate_if.slave (start, act_sel, data_in, bias_in, sel,
//          ready, data_out, sel_in, sel_bias)
//
// Optional feature macro: ACT_BIAS_EN
//   defined   : x = sat16(data_in + bias_in), sel_bias follows sel_in
//   undefined : x = data_in, bias_in ignored, sel_bias tied to 0
//   Timing and latency are identical in both builds.
//
// Sweep timing: ready drops the cycle after start is accepted, stays low for
// N RUN cycles plus one FLUSH cycle, then rises with every entry updated.
// ---------------------------------------------------------------------------
module vec_activate #(
  parameter int LEN_BITS  = 4,
  parameter int FRAC_BITS = 8
) (
  input logic           clk,
  input logic           rst_n,
  vec_activate_if.slave bus
);

  localparam int N = 2 ** LEN_BITS;

  localparam logic [LEN_BITS-1:0] LAST_IDX = LEN_BITS'(N - 1);

  localparam logic [1:0] ACT_IDENTITY = 2'b00;
  localparam logic [1:0] ACT_SIGMOID  = 2'b01;
  localparam logic [1:0] ACT_TANH     = 2'b10;
  localparam logic [1:0] ACT_RELU     = 2'b11;

  // Activation constants are kept at 17 bits so the sigmoid shift-and-add
  // and all clamp comparisons are done without intermediate overflow.
  localparam logic signed [16:0] ONE     = 17'sd1 <<< FRAC_BITS;
  localparam logic signed [16:0] NEG_ONE = -ONE;
  localparam logic signed [16:0] HALF    = 17'sd1 <<< (FRAC_BITS - 1);
  localparam logic signed [16:0] ZERO17  = 17'sd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [LEN_BITS-1:0] idx_q;
  logic [1:0]          act_q;

  logic                s1_valid;
  logic [LEN_BITS-1:0] s1_idx;
  logic signed [15:0]  s1_value;

  logic signed [15:0]  result_mem [N];

  logic                run_active;
  logic signed [15:0]  x;
  logic signed [16:0]  x17;
  logic signed [16:0]  sig17;
  logic signed [15:0]  y;

`ifdef ACT_BIAS_EN
  logic signed [16:0]  sum17;
`else
  // bias_in is deliberately ignored in this build.
  logic                unused_bias;
  assign unused_bias = ^bus.bias_in;
`endif

  // ------------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------------------
  // FSM: next-state logic. start is only honoured in IDLE, so a second start
  // during a sweep is simply ignored.
  // ------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // FSM: outputs. The read selects only walk while RUN; elsewhere they rest
  // at 0.
  // ------------------------------------------------------------------------
  always_comb begin
    run_active   = (state_q == RUN);
    bus.ready    = (state_q == IDLE);
    bus.sel_in   = run_active ? idx_q : '0;
`ifdef ACT_BIAS_EN
    bus.sel_bias = run_active ? idx_q : '0;
`else
    bus.sel_bias = '0;
`endif
  end

  // ------------------------------------------------------------------------
  // Sweep index and activation latch. The activation is captured only when
  // start is accepted so mid-sweep act_sel changes have no effect.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      act_q <= ACT_IDENTITY;
    end else begin
      if (state_q == IDLE && bus.start) begin
        idx_q <= '0;
        act_q <= bus.act_sel;
      end else if (state_q == RUN && idx_q != LAST_IDX) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Element datapath: optional saturating bias add, then activation.
  // Everything here is combinational on the element currently selected by
  // sel_in/sel_bias.
  // ------------------------------------------------------------------------
  always_comb begin
    x     = '0;
    x17   = '0;
    sig17 = '0;
    y     = '0;

`ifdef ACT_BIAS_EN
    sum17 = {bus.data_in[15], bus.data_in} + {bus.bias_in[15], bus.bias_in};
    if (sum17 > 17'sd32767) begin
      x = 16'sh7FFF;
    end else if (sum17 < -17'sd32768) begin
      x = 16'sh8000;
    end else begin
      x = sum17[15:0];
    end
`else
    x = bus.data_in;
`endif

    x17   = {x[15], x};
    sig17 = (x17 >>> 2) + HALF;

    case (act_q)
      ACT_IDENTITY: y = x;
      ACT_SIGMOID: begin
        if (sig17 < ZERO17) begin
          y = '0;
        end else if (sig17 > ONE) begin
          y = ONE[15:0];
        end else begin
          y = sig17[15:0];
        end
      end
      ACT_TANH: begin
        if (x17 > ONE) begin
          y = ONE[15:0];
        end else if (x17 < NEG_ONE) begin
          y = NEG_ONE[15:0];
        end else begin
          y = x;
        end
      end
      ACT_RELU: y = x[15] ? 16'sd0 : x;
      default:  y = x;
    endcase
  end

  // ------------------------------------------------------------------------
  // Stage register S1. It decouples the activation path from the result
  // write, which is why the last element is written during FLUSH.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_value <= '0;
    end else begin
      s1_valid <= run_active;
      if (run_active) begin
        s1_idx   <= idx_q;
        s1_value <= y;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Result vector. Entries persist between sweeps; only reset clears them.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        result_mem[i] <= '0;
      end
    end else if (s1_valid) begin
      result_mem[s1_idx] <= s1_value;
    end
  end

  assign bus.data_out = result_mem[bus.sel];

endmodule

// File: tb/tb_vec_activate.sv
// ---------------------------------------------------------------------------
// tb_vec_activate
//
// Purpose : self-checking bench for vec_activate. Upstream and bias vectors
//           are modelled as arrays read combinationally through sel_in and
//           sel_bias. A behavioural model computes the expected result of
//           every element from the activation rules using integer arithmetic.
//           Honours ACT_BIAS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_vec_activate;

  localparam int LEN_BITS  = 4;
  localparam int FRAC_BITS = 8;
  localparam int N         = 2 ** LEN_BITS;
  localparam int ONE       = 1 << FRAC_BITS;

`ifdef ACT_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  vec_activate_if #(.LEN_BITS(LEN_BITS)) bus ();

  vec_activate #(
    .LEN_BITS (LEN_BITS),
    .FRAC_BITS(FRAC_BITS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic signed [15:0] vec_mem  [N];
  logic signed [15:0] bias_mem [N];
  int                 exp_res  [N];

  int n_checks = 0;
  int n_fail   = 0;

  // Upstream and bias vectors answer the DUT's read selects in the same cycle.
  assign bus.data_in = vec_mem[bus.sel_in];
  assign bus.bias_in = bias_mem[bus.sel_bias];

  // Safety net so the run can never hang.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference activation from the arithmetic rules.
  function automatic int refAct(input int d, input int b, input logic [1:0] a);
    int sum;
    int x;
    int y;
    sum = d + b;
    if (sum > 32767)  sum = 32767;
    if (sum < -32768) sum = -32768;
    x = BIAS_EN ? sum : d;
    case (a)
      2'b00: y = x;
      2'b01: begin
        y = (x >>> 2) + ONE / 2;
        if (y < 0)   y = 0;
        if (y > ONE) y = ONE;
      end
      2'b10: begin
        y = x;
        if (y > ONE)  y = ONE;
        if (y < -ONE) y = -ONE;
      end
      default: y = (x < 0) ? 0 : x;
    endcase
    return y;
  endfunction

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Runs one sweep; optionally fires a second start and flips act_sel while
  // it is in progress. Checks the busy length and the select walk, then
  // updates the model.
  task automatic applyStimulus(input logic [1:0] act, input bit disturb, input string tag);
    int low;
    int sel_err;
    @(negedge clk);
    bus.act_sel = act;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    low     = 0;
    sel_err = 0;
    while (bus.ready !== 1'b1 && low < 60) begin
      if (low < N) begin
        if (bus.sel_in !== LEN_BITS'(low)) sel_err++;
        if (bus.sel_bias !== LEN_BITS'(BIAS_EN ? low : 0)) sel_err++;
      end
      if (disturb && low == 3) begin
        bus.start   = 1'b1;
        bus.act_sel = ~act;
      end
      if (disturb && low == 6) bus.start = 1'b0;
      low++;
      @(negedge clk);
    end
    checkOutput({tag, "_busy_cycles"}, low, N + 1);
    checkOutput({tag, "_sel_walk_errors"}, sel_err, 0);
    checkOutput({tag, "_sel_in_idle"}, int'(bus.sel_in), 0);
    for (int i = 0; i < N; i++) begin
      exp_res[i] = refAct(int'(vec_mem[i]), int'(bias_mem[i]), act);
    end
  endtask

  task automatic readAll(input string tag);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      bus.sel = LEN_BITS'(i);
      #1;
      checkOutput($sformatf("%s_res%0d", tag, i), bus.data_out, exp_res[i]);
    end
  endtask

  // Compares every entry against a 4-entry pattern repeated across the vector.
  task automatic readTable(input string tag, input int t0, input int t1,
                           input int t2, input int t3);
    int tbl [4];
    tbl = '{t0, t1, t2, t3};
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      bus.sel = LEN_BITS'(i);
      #1;
      checkOutput($sformatf("%s_res%0d", tag, i), bus.data_out, tbl[i % 4]);
    end
  endtask

  task automatic loadPattern(input int p0, input int p1, input int p2, input int p3);
    int pat [4];
    pat = '{p0, p1, p2, p3};
    for (int i = 0; i < N; i++) begin
      vec_mem[i]  = 16'(pat[i % 4]);
      bias_mem[i] = '0;
    end
  endtask

  task automatic loadRandom();
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        vec_mem[i] = 16'($urandom_range(0, 2047)) - 16'sd1024;
      end else begin
        vec_mem[i] = 16'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        bias_mem[i] = 16'($urandom);
      end else begin
        bias_mem[i] = 16'($urandom_range(0, 511)) - 16'sd256;
      end
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.act_sel = 2'b00;
    bus.sel     = '0;
    for (int i = 0; i < N; i++) begin
      vec_mem[i]  = '0;
      bias_mem[i] = '0;
      exp_res[i]  = 0;
    end

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_ready", bus.ready, 1);
    checkOutput("rst_sel_in", int'(bus.sel_in), 0);
    checkOutput("rst_sel_bias", int'(bus.sel_bias), 0);
    readAll("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Identity sweep of i*256.
    for (int i = 0; i < N; i++) vec_mem[i] = 16'(i * 256);
    applyStimulus(2'b00, 1'b0, "ident");
    readAll("ident");

    // Reset on RUN cycle 5 discards the sweep and zeroes the results.
    loadRandom();
    @(negedge clk);
    bus.act_sel = 2'b11;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready", bus.ready, 1);
    checkOutput("midrst_sel_in", int'(bus.sel_in), 0);
    for (int i = 0; i < N; i++) exp_res[i] = 0;
    readAll("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed activation cases.
    loadPattern(0, 1024, -512, 256);
    applyStimulus(2'b01, 1'b0, "sigm");
    readTable("sigm", 128, 256, 0, 192);

    loadPattern(300, -300, -100, 100);
    applyStimulus(2'b10, 1'b0, "tanh");
    readTable("tanh", 256, -256, -100, 100);
    applyStimulus(2'b11, 1'b0, "relu");
    readTable("relu", 300, 0, 0, 100);

`ifdef ACT_BIAS_EN
    // Saturating bias add in both directions.
    for (int i = 0; i < N; i++) begin
      vec_mem[i]  = (i % 2 == 0) ? 16'sh7F00 : 16'sh8100;
      bias_mem[i] = (i % 2 == 0) ? 16'sh0200 : 16'shFE00;
    end
    applyStimulus(2'b00, 1'b0, "biassat");
    readTable("biassat", 32767, -32768, 32767, -32768);
`endif

    // Start and act_sel changes mid-sweep must not disturb the sweep.
    loadPattern(300, -300, 2000, -2000);
    applyStimulus(2'b10, 1'b1, "disturb");
    readTable("disturb", 256, -256, 256, -256);

    // Randomized sweeps against the model.
    for (int s = 0; s < 6; s++) begin
      loadRandom();
      applyStimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $sformatf("rand%0d", s));
      readAll($sformatf("rand%0d", s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
